// File: rtl/rgb_pwm_fader_pkg.sv
// Shared encodings for the RGB PWM fader: channel modes, ramp direction, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rgb_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Counter/index width for n states, never narrower than one bit.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Write bus into the fader: one-cycle strobe carrying channel, mode and level.
// Latency: n/a (wiring only).
// Backpressure: none; every strobe is accepted, the last one before commit wins.
interface rgb_pwm_fader_if
  import rgb_pkg::*;
#(
  parameter int CHAN_W   = 2,
  parameter int PWM_BITS = 8
);
  logic                wr_en;
  logic [CHAN_W-1:0]   wr_chan;
  mode_t               wr_mode;
  logic [PWM_BITS-1:0] wr_level;

  modport master (output wr_en, wr_chan, wr_mode, wr_level);
  modport slave  (input  wr_en, wr_chan, wr_mode, wr_level);
endinterface

// File: rtl/rgb_channel.sv
// One PWM channel: shadow/active settings, blink and breathe sequencing, PWM compare.
// Latency: pwm is one register stage behind pwm_cnt; settings commit at period end.
// Backpressure: none; a write while pending simply overwrites the shadow copy.
module rgb_channel
  import rgb_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int BLINK_PERIODS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                period_end,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wr_hit,
  input  mode_t               wr_mode,
  input  logic [PWM_BITS-1:0] wr_level,
  output logic                pwm,
  output logic                pending
);
  localparam int BC_W = width_min1(BLINK_PERIODS);

  mode_t               act_mode, act_mode_nxt;
  mode_t               sh_mode, sh_mode_nxt;
  logic [PWM_BITS-1:0] act_level, act_level_nxt;
  logic [PWM_BITS-1:0] sh_level, sh_level_nxt;
  logic [PWM_BITS-1:0] duty, duty_nxt;
  dir_t                dir, dir_nxt;
  logic                blink_on, blink_on_nxt;
  logic [BC_W-1:0]     blink_cnt, blink_cnt_nxt;
  logic                pending_nxt;
  logic                pwm_nxt;
  logic [PWM_BITS-1:0] eff_duty;

  // Next-state: shadow capture, period-boundary commit, blink/breathe stepping, PWM compare.
  always_comb begin
    act_mode_nxt  = act_mode;
    act_level_nxt = act_level;
    sh_mode_nxt   = sh_mode;
    sh_level_nxt  = sh_level;
    duty_nxt      = duty;
    dir_nxt       = dir;
    blink_on_nxt  = blink_on;
    blink_cnt_nxt = blink_cnt;
    pending_nxt   = pending;
    eff_duty      = '0;

    if (wr_hit) begin
      sh_mode_nxt  = wr_mode;
      sh_level_nxt = wr_level;
    end

    if (period_end) begin
      if (pending || wr_hit) begin
        // A write landing on the boundary itself bypasses the shadow so it is not lost.
        act_mode_nxt  = wr_hit ? wr_mode  : sh_mode;
        act_level_nxt = wr_hit ? wr_level : sh_level;
        duty_nxt      = '0;
        dir_nxt       = DIR_UP;
        blink_on_nxt  = 1'b1;
        blink_cnt_nxt = '0;
        pending_nxt   = 1'b0;
      end else begin
        case (act_mode)
          MODE_BLINK: begin
            if (blink_cnt == BC_W'(BLINK_PERIODS - 1)) begin
              blink_cnt_nxt = '0;
              blink_on_nxt  = ~blink_on;
            end else begin
              blink_cnt_nxt = blink_cnt + BC_W'(1);
            end
          end
          MODE_BREATHE: begin
            // Hold one extra period at each extreme while turning around.
            if (dir == DIR_UP) begin
              if (duty < act_level) duty_nxt = duty + PWM_BITS'(1);
              else                  dir_nxt  = DIR_DOWN;
            end else begin
              if (duty != '0) duty_nxt = duty - PWM_BITS'(1);
              else            dir_nxt  = DIR_UP;
            end
          end
          default: ;
        endcase
      end
    end else if (wr_hit) begin
      pending_nxt = 1'b1;
    end

    case (act_mode)
      MODE_STATIC:  eff_duty = act_level;
      MODE_BLINK:   eff_duty = blink_on ? act_level : '0;
      MODE_BREATHE: eff_duty = duty;
      default:      eff_duty = '0;
    endcase

    // All-ones duty means solid on rather than on for all but one tick.
    pwm_nxt = (pwm_cnt < eff_duty) || (&eff_duty);
  end

  // State register; reset drops every setting back to OFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_mode  <= MODE_OFF;
      act_level <= '0;
      sh_mode   <= MODE_OFF;
      sh_level  <= '0;
      duty      <= '0;
      dir       <= DIR_UP;
      blink_on  <= 1'b0;
      blink_cnt <= '0;
      pending   <= 1'b0;
      pwm       <= 1'b0;
    end else begin
      act_mode  <= act_mode_nxt;
      act_level <= act_level_nxt;
      sh_mode   <= sh_mode_nxt;
      sh_level  <= sh_level_nxt;
      duty      <= duty_nxt;
      dir       <= dir_nxt;
      blink_on  <= blink_on_nxt;
      blink_cnt <= blink_cnt_nxt;
      pending   <= pending_nxt;
      pwm       <= pwm_nxt;
    end
  end

endmodule

// File: rtl/rgb_pwm_fader.sv
// Multi-channel PWM LED fader with OFF/STATIC/BLINK/BREATHE modes and glitch-free updates.
// Latency: pwm registered one cycle after pwm_cnt; writes commit at the next period end.
// Backpressure: none; writes to channels outside 0..CHANNELS-1 are dropped.
module rgb_pwm_fader
  import rgb_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 188,
  parameter int BLINK_PERIODS = 128
) (
  input  logic                clk,
  input  logic                rst,
  rgb_pwm_fader_if.slave      wr,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] pending
);
  localparam int CHAN_W = width_min1(CHANNELS);
  localparam int PS_W   = width_min1(PRESCALE);

  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                period_end;
  logic [CHANNELS-1:0] wr_hit;

  assign tick       = (presc == PS_W'(PRESCALE - 1));
  assign period_end = tick && (&pwm_cnt);

  // Shared timebase: prescaler produces ticks, pwm_cnt walks one PWM period.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + PS_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_chan
      // An out-of-range wr_chan matches no instance, so it changes nothing.
      assign wr_hit[c] = wr.wr_en && (wr.wr_chan == CHAN_W'(c));

      rgb_channel #(
        .PWM_BITS      (PWM_BITS),
        .BLINK_PERIODS (BLINK_PERIODS)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .period_end (period_end),
        .pwm_cnt    (pwm_cnt),
        .wr_hit     (wr_hit[c]),
        .wr_mode    (wr.wr_mode),
        .wr_level   (wr.wr_level),
        .pwm        (pwm[c]),
        .pending    (pending[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader with a 16-tick period and one-cycle ticks.
// Latency: pwm sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_rgb_pwm_fader;
  import rgb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pwm;
  logic [2:0] pending;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;
  int hc[3];

  rgb_pwm_fader_if #(.CHAN_W(2), .PWM_BITS(4)) wr_if ();

  rgb_pwm_fader #(
    .CHANNELS      (3),
    .PWM_BITS      (4),
    .PRESCALE      (1),
    .BLINK_PERIODS (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr_if),
    .pwm     (pwm),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic wr_drive(input int ch, input mode_t m, input int lvl);
    wr_if.wr_en    = 1'b1;
    wr_if.wr_chan  = 2'(ch);
    wr_if.wr_mode  = m;
    wr_if.wr_level = 4'(lvl);
    step();
    wr_if.wr_en    = 1'b0;
  endtask

  // Step until the edge count sits at the given phase within the 16-cycle period.
  task automatic to_phase(input int ph);
    while ((ncyc % 16) != ph) step();
  endtask

  // Count high cycles per channel over the next full PWM period seen at the output.
  task automatic measure();
    to_phase(0);
    for (int c = 0; c < 3; c++) hc[c] = 0;
    repeat (16) begin
      step();
      for (int c = 0; c < 3; c++) hc[c] += int'(pwm[c]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         br[10];
    int         bl[6];
    logic [2:0] acc;

    br = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
    bl = '{8, 8, 0, 0, 8, 8};

    rst            = 1'b1;
    wr_if.wr_en    = 1'b0;
    wr_if.wr_chan  = 2'd0;
    wr_if.wr_mode  = MODE_OFF;
    wr_if.wr_level = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    ncyc = 0;

    chk("reset_pwm", int'(pwm), 0);
    chk("reset_pending", int'(pending), 0);

    acc = '0;
    repeat (64) begin
      step();
      acc |= pwm | pending;
    end
    chk("idle_quiet", int'(acc), 0);

    // STATIC written mid-period: pending until boundary, then 4 of 16 high.
    to_phase(4);
    wr_drive(1, MODE_STATIC, 4);
    chk("static_pend_set", int'(pending), 2);
    to_phase(15);
    chk("static_pend_hold", int'(pending), 2);
    step();
    chk("static_pend_clr", int'(pending), 0);
    measure();
    chk("static4_ch1", hc[1], 4);
    chk("static4_ch0", hc[0], 0);
    chk("static4_ch2", hc[2], 0);

    to_phase(7);
    wr_drive(1, MODE_STATIC, 15);
    measure();
    chk("static15_ch1", hc[1], 16);

    // BREATHE level 3 triangle.
    to_phase(3);
    wr_drive(0, MODE_BREATHE, 3);
    for (int i = 0; i < 10; i++) begin
      measure();
      chk($sformatf("breathe_p%0d", i), hc[0], br[i]);
    end
    chk("breathe_ch1_kept", hc[1], 16);

    // BLINK level 8, two periods on, two off.
    to_phase(9);
    wr_drive(2, MODE_BLINK, 8);
    for (int i = 0; i < 6; i++) begin
      measure();
      chk($sformatf("blink_p%0d", i), hc[2], bl[i]);
    end

    // Write on the boundary commits at once; out-of-range channel is ignored.
    to_phase(15);
    wr_drive(1, MODE_STATIC, 6);
    chk("edge_wr_pending", int'(pending), 0);
    measure();
    chk("edge_wr_ch1", hc[1], 6);
    to_phase(5);
    wr_drive(3, MODE_STATIC, 15);
    chk("bad_chan_pending", int'(pending), 0);
    measure();
    chk("bad_chan_ch1", hc[1], 6);

    // Reset in the middle of a ramp, with a coincident write that must be dropped.
    to_phase(4);
    wr_drive(0, MODE_BREATHE, 3);
    measure();
    chk("ramp_p0", hc[0], 0);
    measure();
    chk("ramp_p1", hc[0], 1);
    step();
    chk("pre_rst_pwm0", int'(pwm[0]), 1);
    rst            = 1'b1;
    wr_if.wr_en    = 1'b1;
    wr_if.wr_chan  = 2'd1;
    wr_if.wr_mode  = MODE_STATIC;
    wr_if.wr_level = 4'd15;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    wr_if.wr_en = 1'b0;
    ncyc        = 0;
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_pending", int'(pending), 0);
    measure();
    chk("post_rst_ch0", hc[0], 0);
    chk("post_rst_ch1", hc[1], 0);
    chk("post_rst_ch2", hc[2], 0);

    to_phase(4);
    wr_drive(1, MODE_STATIC, 4);
    chk("post_rst_pend", int'(pending), 2);
    measure();
    chk("post_rst_static4", hc[1], 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 Parameter CHANNELS, default 3, number of independent PWM channels (blue, green, red order for channels 0..2).
REQ-002 Parameter PWM_BITS, default 8, duty/counter width; PWM period = 2^PWM_BITS ticks.
REQ-003 Parameter PRESCALE, default 188, clk cycles per tick (≥1); 48 MHz → ~1 kHz PWM at defaults.
REQ-004 Parameter BLINK_PERIODS, default 128, PWM periods per blink half-phase (≥1).
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_en  input  1  write strobe, one-cycle.
REQ-008 wr_chan  input  $clog2(CHANNELS) (min 1)  target channel.
REQ-009 wr_mode  input  2  0 OFF, 1 STATIC, 2 BLINK, 3 BREATHE.
REQ-010 wr_level  input  PWM_BITS  target/peak duty.
REQ-011 pwm  output  CHANNELS  registered PWM drive, feeds SB_RGBA_DRV RGBnPWM.
REQ-012 pending  output  CHANNELS  per-channel flag: write accepted, not yet committed.

Function
REQ-013 Prescaler counts 0..PRESCALE-1, wraps; tick asserted the cycle it equals PRESCALE-1.
REQ-014 pwm_cnt (PWM_BITS) increments on tick, wraps all-ones→0; period_end = tick && pwm_cnt all-ones.
REQ-015 Per channel: active mode/level, shadow mode/level, duty (PWM_BITS), dir (UP/DOWN), blink phase, blink counter.
REQ-016 wr_en with wr_chan < CHANNELS loads that channel's shadow and sets pending next cycle; wr_chan ≥ CHANNELS ignored, no state change.
REQ-017 Second write before commit overwrites shadow; last write wins.
REQ-018 At period_end every pending channel copies shadow to active and clears pending; writes never take effect mid-period (glitch-free).
REQ-019 Write coincident with period_end to a channel is committed at that same period_end; pending stays 0.
REQ-020 On commit: duty←0, dir←UP, blink phase←ON, blink counter←0.
REQ-021 OFF: effective duty 0. STATIC: effective duty = level.
REQ-022 BLINK: blink counter increments per period_end; at BLINK_PERIODS-1 wraps to 0 and toggles phase; effective duty = level when ON, else 0.
REQ-023 BREATHE, per period_end: UP: duty<level → duty+1, else dir←DOWN; DOWN: duty>0 → duty-1, else dir←UP. Triangle period 2·level+2 PWM periods; level 0 → duty stays 0.
REQ-024 pwm[c] next cycle = (pwm_cnt < eff_duty) || (eff_duty all-ones); all-ones is fully on, 0 fully off.
REQ-025 Latency: pwm reflects pwm_cnt/eff_duty of previous cycle (one register stage).
REQ-026 No saturation/overflow: duty never leaves 0..level.

Reset
REQ-027 rst high at posedge: prescaler, pwm_cnt, all active/shadow state to 0 (mode OFF), dir UP, pending 0, pwm 0 next cycle.
REQ-028 rst overrides a coincident wr_en; reset mid-ramp or mid-blink discards all state.

Structure
REQ-029 Mode encodings (OFF/STATIC/BLINK/BREATHE) and dir encoding in shared package rgb_pkg.
REQ-030 Per-channel state machine is sub-module rgb_channel, instantiated CHANNELS times via generate; prescaler/pwm_cnt shared in top.

Verification (PRESCALE=1, PWM_BITS=4, BLINK_PERIODS=2, CHANNELS=3)
REQ-031 Reset then idle 64 cycles -> pwm==3'b000, pending==0 throughout.
REQ-032 Write ch1 STATIC level 4 mid-period -> pending[1]=1 until period_end; next period pwm[1] high exactly 4 of 16 cycles; level 15 -> high 16/16.
REQ-033 Write ch0 BREATHE level 3 -> high-cycle counts per period 0,1,2,3,3,2,1,0,0,1... repeating.
REQ-034 Write ch2 BLINK level 8 -> periods high 8/16 ×2, 0/16 ×2, repeating.
REQ-035 Write on period_end cycle and wr_chan=3 (invalid) same test -> valid write committed immediately, pending stays 0; invalid write has no effect.
REQ-036 Assert rst during BREATHE ramp (duty 2) -> pwm 0 next cycle, mode OFF, new STATIC write behaves as REQ-032.
